randomic_ca_hybrid: RTL
=======================

RANDOMIC_CA_HYBRID -- requirements
Module: randomic_ca_hybrid

Interface
REQ-001 SHALL have parameter Width, default 8: number of CA cells and output bits, minimum 3.
REQ-002 SHALL have parameter Seed, default 1 (Width bits): CA state after reset and the substitute for an all-zero seed.
REQ-003 SHALL have parameter WarmUp, default 16: number of CA advances discarded after reset or load, range 0..65535.
REQ-004 SHALL have parameter HybridMask, default alternating 1010... (Width bits): per cell, 1 selects rule 150 and 0 selects rule 90 in hybrid mode.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port ce, input, 1 bit: advance enable.
REQ-008 SHALL have port load, input, 1 bit: seed load strobe.
REQ-009 SHALL have port seed, input, Width bits: seed value captured when load is high.
REQ-010 SHALL have port mode, input, 1 bit: 0 selects rule 30, 1 selects hybrid 90/150.
REQ-011 SHALL have port ready, input, 1 bit: consumer accepts random.
REQ-012 SHALL have port random, output, Width bits: registered output word.
REQ-013 SHALL have port valid, output, 1 bit: random holds an unconsumed word.
REQ-014 SHALL have port reseeds, output, 8 bits: saturating count of automatic reseeds.

Function
REQ-015 SHALL compute the next state with null boundaries, where L=state[i+1] and R=state[i-1] and an out-of-range neighbour reads as 0.
- Rule 30: next[i]=L^(C|R).
- Rule 90: next[i]=L^R.
- Rule 150: next[i]=L^C^R.
REQ-016 SHALL implement a two-state FSM, WARMUP and RUN; reset and load enter WARMUP with the warm-up counter at 0.
REQ-017 SHALL, in WARMUP, on each cycle with ce high, advance the state and increment the counter, with valid held at 0.
REQ-018 SHALL enter RUN once WarmUp advances have been made in WARMUP; with WarmUp=0, WARMUP exits on the first cycle without advancing.
REQ-019 SHALL, in RUN, when ce is high and (valid is low or ready is high), advance the state, register random<=next and set valid<=1 at the same edge (one-cycle latency).
REQ-020 SHALL, in RUN, when valid is high and ready is low, hold both random and the CA state, so that no word is ever skipped.
REQ-021 SHALL clear valid on a handshake (valid and ready high) in a cycle with no new word (ce low).
REQ-022 SHALL give load priority over ce: state<=seed, valid<=0 and random unchanged at the next edge.
REQ-023 SHALL sample mode at each advance, so a change takes effect on the next advance without restarting warm-up.

Reset
REQ-024 SHALL, on rst high, asynchronously set: state=Seed, FSM=WARMUP, counter=0, random=0, valid=0, reseeds=0.
REQ-025 SHALL, when rst asserts mid-operation, discard any pending word; there is no handshake completion across reset.

Configuration
REQ-026 SHALL, with macro RANDOMIC_CA_STALL_DETECT_EN defined, replace any all-zero computed next state, and any all-zero loaded seed, by Seed, and increment reseeds (saturating at 255).
REQ-027 SHALL, without RANDOMIC_CA_STALL_DETECT_EN, apply no substitution (zero stays zero) and tie reseeds to 0.

Structure
REQ-028 SHALL place the rule-select encodings (RULE30, RULE90_150) and the FSM state encodings in the shared package randomic_pkg.
REQ-029 SHALL implement the per-cell next-state logic in one sub-module, randomic_ca_cell, instantiated Width times.

Verification
REQ-030 SHALL cover warm-up: Width=8, Seed=8'h01, WarmUp=4, mode=0, ce=1, ready=1 -> four silent advances (03, 06, 0D, 19), then random=8'h37 with valid=1.
REQ-031 SHALL cover backpressure: in RUN, ready=0 for 5 cycles -> random and valid held constant; ready=1 -> next word follows with no gap and no skipped state.
REQ-032 SHALL cover hybrid mode: mode=1, HybridMask=8'h00, load seed=8'h01, WarmUp=0 -> first word 8'h02.
REQ-033 SHALL cover load mid-run: load=1 with ce=1 -> valid=0 next cycle, WarmUp advances, then output restarts from the new seed.
REQ-034 SHALL cover zero seed: load seed=8'h00 -> with the macro, state=Seed and reseeds=1; without it, state stays 0 and reseeds=0.
REQ-035 SHALL cover async reset: rst pulse between clock edges -> valid=0, random=0 and reseeds=0 immediately.

Source files
------------

// File: rtl/randomic_pkg.sv
// Shared encodings for the randomic cellular-automaton generator.
package randomic_pkg;

  typedef enum logic {
    RULE30     = 1'b0,
    RULE90_150 = 1'b1
  } rule_e;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } fsm_e;

endpackage

// File: rtl/randomic_ca_cell.sv
// One CA cell: next value from left/centre/right under rule 30 or hybrid 90/150.
module randomic_ca_cell
  import randomic_pkg::*;
(
  input  logic  l,
  input  logic  c,
  input  logic  r,
  input  rule_e rule,
  input  logic  use150,
  output logic  nxt
);

  always_comb begin
    nxt = 1'b0;
    case (rule)
      RULE30:  nxt = l ^ (c | r);
      default: nxt = use150 ? (l ^ c ^ r) : (l ^ r);
    endcase
  end

endmodule

// File: rtl/randomic_ca_hybrid.sv
// CA random word generator with warm-up, valid/ready output and seed load.
// Optional zero-state reseeding via RANDOMIC_CA_STALL_DETECT_EN.
module randomic_ca_hybrid
  import randomic_pkg::*;
#(
  parameter int               Width      = 8,
  parameter logic [Width-1:0] Seed       = Width'(1),
  parameter int               WarmUp     = 16,
  parameter logic [Width-1:0] HybridMask = Width'({(Width+1)/2{2'b10}})
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [Width-1:0] seed,
  input  logic             mode,
  input  logic             ready,
  output logic [Width-1:0] random,
  output logic             valid,
  output logic [7:0]       reseeds
);

  fsm_e             fsm, fsm_n;
  logic [15:0]      cnt, cnt_n;
  logic [Width-1:0] state, state_n, random_n;
  logic [Width-1:0] step_raw, step_val, load_val, left, right;
  logic             valid_n, step_zero, load_zero, bump;
  rule_e            rule;

  assign rule  = rule_e'(mode);
  // Null boundaries: out-of-range neighbours shift in as zero.
  assign left  = {1'b0, state[Width-1:1]};
  assign right = {state[Width-2:0], 1'b0};

  for (genvar i = 0; i < Width; i++) begin : g_cell
    randomic_ca_cell u_cell (
      .l      (left[i]),
      .c      (state[i]),
      .r      (right[i]),
      .rule   (rule),
      .use150 (HybridMask[i]),
      .nxt    (step_raw[i])
    );
  end

`ifdef RANDOMIC_CA_STALL_DETECT_EN
  assign step_zero = (step_raw == '0);
  assign load_zero = (seed == '0);
  assign step_val  = step_zero ? Seed : step_raw;
  assign load_val  = load_zero ? Seed : seed;
`else
  assign step_zero = 1'b0;
  assign load_zero = 1'b0;
  assign step_val  = step_raw;
  assign load_val  = seed;
`endif

  always_comb begin
    fsm_n    = fsm;
    cnt_n    = cnt;
    state_n  = state;
    random_n = random;
    valid_n  = valid;
    bump     = 1'b0;
    if (load) begin
      state_n = load_val;
      valid_n = 1'b0;
      fsm_n   = WARMUP;
      cnt_n   = '0;
      bump    = load_zero;
    end else begin
      case (fsm)
        WARMUP: begin
          if (WarmUp == 0) fsm_n = RUN;
          else if (ce) begin
            state_n = step_val;
            cnt_n   = cnt + 16'd1;
            bump    = step_zero;
            if ({1'b0, cnt} + 17'd1 == 17'(WarmUp)) fsm_n = RUN;
          end
        end
        default: begin
          // Stall the CA itself under backpressure so no word is skipped.
          if (ce && (!valid || ready)) begin
            state_n  = step_val;
            random_n = step_val;
            valid_n  = 1'b1;
            bump     = step_zero;
          end else if (valid && ready) begin
            valid_n = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm     <= WARMUP;
      cnt     <= '0;
      state   <= Seed;
      random  <= '0;
      valid   <= 1'b0;
      reseeds <= '0;
    end else begin
      fsm    <= fsm_n;
      cnt    <= cnt_n;
      state  <= state_n;
      random <= random_n;
      valid  <= valid_n;
      if (bump && reseeds != 8'hFF) reseeds <= reseeds + 8'd1;
    end
  end

endmodule
